// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg: shared AXI widths, default IDs and the read-arbiter state/grant encodings.
package axi_rd_arbiter_pkg;
    localparam int AXI_ADDR_W = 64;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_STRB_W = 8;
    localparam logic [AXI_ID_W-1:0] AXI_ID_IF  = 4'h0;
    localparam logic [AXI_ID_W-1:0] AXI_ID_MEM = 4'h1;
    typedef enum logic [2:0] {ARB_IDLE, ARB_AR_IF, ARB_AR_MEM, ARB_R_IF, ARB_R_MEM} arb_state_e;
    typedef enum logic {GNT_IF, GNT_MEM} grant_e;
endpackage

// File: rtl/axi_wr_tracker.sv
// axi_wr_tracker: holds wr_pend from the AW handshake until the B handshake, gating AW meanwhile.
module axi_wr_tracker (
    input  logic clk,
    input  logic rst,
    input  logic mem_awvalid,
    input  logic m_awready,
    input  logic m_bvalid,
    input  logic mem_bready,
    output logic m_awvalid,
    output logic mem_awready,
    output logic wr_pend
);
    assign m_awvalid   = mem_awvalid & ~wr_pend;
    assign mem_awready = m_awready & ~wr_pend;
    // set wins over clear so a write accepted alongside a stale B stays outstanding
    always_ff @(posedge clk)
        if (rst) wr_pend <= 1'b0;
        else if (m_awvalid & m_awready) wr_pend <= 1'b1;
        else if (m_bvalid & mem_bready) wr_pend <= 1'b0;
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI4 master port between if (read) and mem (read/write) masters.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-break; default is fixed priority mem > if.
module axi_rd_arbiter
    import axi_rd_arbiter_pkg::*;
#(
    parameter logic [AXI_ID_W-1:0] ID_IF  = AXI_ID_IF,
    parameter logic [AXI_ID_W-1:0] ID_MEM = AXI_ID_MEM
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_arvalid,
    input  logic [AXI_ADDR_W-1:0] if_araddr,
    input  logic [AXI_LEN_W-1:0]  if_arlen,
    input  logic [2:0]            if_arsize,
    input  logic [1:0]            if_arburst,
    output logic                  if_arready,
    output logic                  if_rvalid,
    output logic [AXI_DATA_W-1:0] if_rdata,
    output logic [1:0]            if_rresp,
    output logic                  if_rlast,
    input  logic                  if_rready,
    input  logic                  mem_arvalid,
    input  logic [AXI_ADDR_W-1:0] mem_araddr,
    input  logic [AXI_LEN_W-1:0]  mem_arlen,
    input  logic [2:0]            mem_arsize,
    input  logic [1:0]            mem_arburst,
    output logic                  mem_arready,
    output logic                  mem_rvalid,
    output logic [AXI_DATA_W-1:0] mem_rdata,
    output logic [1:0]            mem_rresp,
    output logic                  mem_rlast,
    input  logic                  mem_rready,
    input  logic                  mem_awvalid,
    input  logic [AXI_ADDR_W-1:0] mem_awaddr,
    input  logic [AXI_LEN_W-1:0]  mem_awlen,
    input  logic [2:0]            mem_awsize,
    input  logic [1:0]            mem_awburst,
    output logic                  mem_awready,
    input  logic                  mem_wvalid,
    input  logic [AXI_DATA_W-1:0] mem_wdata,
    input  logic [AXI_STRB_W-1:0] mem_wstrb,
    input  logic                  mem_wlast,
    output logic                  mem_wready,
    output logic                  mem_bvalid,
    output logic [1:0]            mem_bresp,
    input  logic                  mem_bready,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [AXI_ADDR_W-1:0] m_araddr,
    output logic [AXI_LEN_W-1:0]  m_arlen,
    output logic [2:0]            m_arsize,
    output logic [1:0]            m_arburst,
    output logic [AXI_ID_W-1:0]   m_arid,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [AXI_DATA_W-1:0] m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rlast,
    input  logic [AXI_ID_W-1:0]   m_rid,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [AXI_ADDR_W-1:0] m_awaddr,
    output logic [AXI_LEN_W-1:0]  m_awlen,
    output logic [2:0]            m_awsize,
    output logic [1:0]            m_awburst,
    output logic [AXI_ID_W-1:0]   m_awid,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    output logic [AXI_DATA_W-1:0] m_wdata,
    output logic [AXI_STRB_W-1:0] m_wstrb,
    output logic                  m_wlast,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    input  logic [1:0]            m_bresp,
    input  logic [AXI_ID_W-1:0]   m_bid,
    output logic                  rid_err
);
    arb_state_e state, state_nxt;
    logic wr_pend, pref_mem, mem_pick, ar_if, ar_mem, r_if, r_mem, r_done;
    logic unused_bid;
    assign unused_bid = ^m_bid;
    assign ar_if  = state == ARB_AR_IF;
    assign ar_mem = state == ARB_AR_MEM;
    assign r_if   = state == ARB_R_IF;
    assign r_mem  = state == ARB_R_MEM;
`ifdef ARB_ROUND_ROBIN_EN
    grant_e last_grant;
    assign pref_mem = last_grant == GNT_IF;
    always_ff @(posedge clk)
        if (rst) last_grant <= GNT_MEM;
        else if (m_arvalid & m_arready) last_grant <= ar_mem ? GNT_MEM : GNT_IF;
`else
    assign pref_mem = 1'b1;
`endif
    // mem reads may not overtake an unacknowledged mem write
    assign mem_pick = mem_arvalid & ~wr_pend & (pref_mem | ~if_arvalid);
    assign r_done   = m_rvalid & m_rready & m_rlast;
    always_ff @(posedge clk)
        if (rst) state <= ARB_IDLE;
        else state <= state_nxt;
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:   state_nxt = mem_pick ? ARB_AR_MEM : if_arvalid ? ARB_AR_IF : ARB_IDLE;
            ARB_AR_IF:  state_nxt = m_arready ? ARB_R_IF : ARB_AR_IF;
            ARB_AR_MEM: state_nxt = m_arready ? ARB_R_MEM : ARB_AR_MEM;
            ARB_R_IF:   state_nxt = r_done ? ARB_IDLE : ARB_R_IF;
            ARB_R_MEM:  state_nxt = r_done ? ARB_IDLE : ARB_R_MEM;
            default:    state_nxt = ARB_IDLE;
        endcase
    end
    assign m_arvalid   = ar_if | ar_mem;
    assign m_araddr    = ar_if ? if_araddr  : ar_mem ? mem_araddr  : '0;
    assign m_arlen     = ar_if ? if_arlen   : ar_mem ? mem_arlen   : '0;
    assign m_arsize    = ar_if ? if_arsize  : ar_mem ? mem_arsize  : '0;
    assign m_arburst   = ar_if ? if_arburst : ar_mem ? mem_arburst : '0;
    assign m_arid      = ar_if ? ID_IF      : ar_mem ? ID_MEM      : '0;
    assign if_arready  = ar_if & m_arready;
    assign mem_arready = ar_mem & m_arready;
    assign m_rready    = r_if ? if_rready : r_mem & mem_rready;
    assign if_rvalid   = r_if & m_rvalid;
    assign if_rdata    = r_if ? m_rdata : '0;
    assign if_rresp    = r_if ? m_rresp : '0;
    assign if_rlast    = r_if & m_rlast;
    assign mem_rvalid  = r_mem & m_rvalid;
    assign mem_rdata   = r_mem ? m_rdata : '0;
    assign mem_rresp   = r_mem ? m_rresp : '0;
    assign mem_rlast   = r_mem & m_rlast;
    // mismatched beats are flagged but still forwarded
    assign rid_err = m_rvalid & m_rready & ((r_if & (m_rid != ID_IF)) | (r_mem & (m_rid != ID_MEM)));
    axi_wr_tracker u_wr (
        .clk        (clk),
        .rst        (rst),
        .mem_awvalid(mem_awvalid),
        .m_awready  (m_awready),
        .m_bvalid   (m_bvalid),
        .mem_bready (mem_bready),
        .m_awvalid  (m_awvalid),
        .mem_awready(mem_awready),
        .wr_pend    (wr_pend)
    );
    assign m_awaddr   = mem_awaddr;
    assign m_awlen    = mem_awlen;
    assign m_awsize   = mem_awsize;
    assign m_awburst  = mem_awburst;
    assign m_awid     = ID_MEM;
    assign m_wvalid   = mem_wvalid;
    assign m_wdata    = mem_wdata;
    assign m_wstrb    = mem_wstrb;
    assign m_wlast    = mem_wlast;
    assign mem_wready = m_wready;
    assign mem_bvalid = m_bvalid;
    assign mem_bresp  = m_bresp;
    assign m_bready   = mem_bready;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized checks of axi_rd_arbiter against an arbitration model.
module tb_axi_rd_arbiter;
    import axi_rd_arbiter_pkg::*;
    logic clk = 1'b0, rst;
    always #5 clk = ~clk;
    logic if_arvalid, if_arready, if_rvalid, if_rlast, if_rready;
    logic [63:0] if_araddr, if_rdata;
    logic [7:0] if_arlen;
    logic [2:0] if_arsize;
    logic [1:0] if_arburst, if_rresp;
    logic mem_arvalid, mem_arready, mem_rvalid, mem_rlast, mem_rready;
    logic [63:0] mem_araddr, mem_rdata;
    logic [7:0] mem_arlen;
    logic [2:0] mem_arsize;
    logic [1:0] mem_arburst, mem_rresp;
    logic mem_awvalid, mem_awready, mem_wvalid, mem_wlast, mem_wready, mem_bvalid, mem_bready;
    logic [63:0] mem_awaddr, mem_wdata;
    logic [7:0] mem_awlen, mem_wstrb;
    logic [2:0] mem_awsize;
    logic [1:0] mem_awburst, mem_bresp;
    logic m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [63:0] m_araddr, m_rdata;
    logic [7:0] m_arlen;
    logic [2:0] m_arsize;
    logic [1:0] m_arburst, m_rresp;
    logic [3:0] m_arid, m_rid;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_wlast, m_bvalid, m_bready;
    logic [63:0] m_awaddr, m_wdata;
    logic [7:0] m_awlen, m_wstrb;
    logic [2:0] m_awsize;
    logic [1:0] m_awburst, m_bresp;
    logic [3:0] m_awid, m_bid;
    logic rid_err;
    int total = 0, passed = 0, fails = 0;
    bit model_last_mem;

    axi_rd_arbiter dut (
        .clk(clk), .rst(rst),
        .if_arvalid(if_arvalid), .if_araddr(if_araddr), .if_arlen(if_arlen), .if_arsize(if_arsize),
        .if_arburst(if_arburst), .if_arready(if_arready), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .if_rresp(if_rresp), .if_rlast(if_rlast), .if_rready(if_rready),
        .mem_arvalid(mem_arvalid), .mem_araddr(mem_araddr), .mem_arlen(mem_arlen), .mem_arsize(mem_arsize),
        .mem_arburst(mem_arburst), .mem_arready(mem_arready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .mem_rresp(mem_rresp), .mem_rlast(mem_rlast), .mem_rready(mem_rready),
        .mem_awvalid(mem_awvalid), .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen), .mem_awsize(mem_awsize),
        .mem_awburst(mem_awburst), .mem_awready(mem_awready), .mem_wvalid(mem_wvalid), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_wlast(mem_wlast), .mem_wready(mem_wready), .mem_bvalid(mem_bvalid),
        .mem_bresp(mem_bresp), .mem_bready(mem_bready),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arlen(m_arlen),
        .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid), .m_rvalid(m_rvalid),
        .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid), .m_wvalid(m_wvalid),
        .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp), .m_bid(m_bid),
        .rid_err(rid_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // arbitration rule: mem wins a tie unless round-robin says it was served last
    function automatic bit pick_mem(input bit rif, input bit rmem);
`ifdef ARB_ROUND_ROBIN_EN
        return rmem & (!rif | !model_last_mem);
`else
        return rmem;
`endif
    endfunction

    task automatic reset_dut();
        rst = 1;
        {if_arvalid, if_rready, mem_arvalid, mem_rready, mem_awvalid, mem_wvalid, mem_bready} = '0;
        {m_arready, m_rvalid, m_rlast, m_awready, m_wready, m_bvalid} = '0;
        {if_araddr, if_arlen, if_arsize, if_arburst, mem_araddr, mem_arlen, mem_arsize, mem_arburst} = '0;
        {mem_awaddr, mem_awlen, mem_awsize, mem_awburst, mem_wdata, mem_wstrb, mem_wlast} = '0;
        {m_rdata, m_rresp, m_rid, m_bresp, m_bid} = '0;
        tick();
        tick();
        rst = 0;
        model_last_mem = 1;
        #1;
    endtask

    task automatic ar_phase(input bit mem, input logic [63:0] addr, input logic [7:0] len, input string tag);
        int n = 0;
        while (!m_arvalid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_ar_wait"}, 64'(n < 20), 64'd1);
        chk({tag, "_araddr"}, m_araddr, addr);
        chk({tag, "_arid"}, 64'(m_arid), mem ? 64'h1 : 64'h0);
        chk({tag, "_arlen"}, 64'(m_arlen), 64'(len));
        chk({tag, "_arsize"}, 64'(m_arsize), 64'(mem ? mem_arsize : if_arsize));
        m_arready = 1;
        #1;
        chk({tag, "_arready"}, {62'd0, if_arready, mem_arready}, mem ? 64'b01 : 64'b10);
        tick();
        m_arready = 0;
        if (mem) mem_arvalid = 0; else if_arvalid = 0;
        model_last_mem = mem;
        #1;
    endtask

    task automatic r_phase(input bit mem, input int beats, input logic [3:0] rid, input logic [63:0] d0, input string tag);
        logic [63:0] d;
        for (int b = 0; b < beats; b++) begin
            d = (b == 0) ? d0 : {$urandom, $urandom};
            m_rvalid = 1;
            m_rdata = d;
            m_rid = rid;
            m_rlast = (b == beats - 1);
            m_rresp = 2'($urandom);
            if ($urandom % 4 == 0) begin
                if_rready = 0;
                mem_rready = 0;
                #1;
                chk({tag, "_stall"}, {62'd0, m_rready, rid_err}, 64'd0);
                tick();
            end
            if_rready = !mem;
            mem_rready = mem;
            #1;
            chk({tag, "_rvalid"}, {62'd0, if_rvalid, mem_rvalid}, mem ? 64'b01 : 64'b10);
            chk({tag, "_rdata"}, mem ? mem_rdata : if_rdata, d);
            chk({tag, "_rlast"}, 64'(mem ? mem_rlast : if_rlast), 64'(b == beats - 1));
            chk({tag, "_rresp"}, 64'(mem ? mem_rresp : if_rresp), 64'(m_rresp));
            chk({tag, "_rid_err"}, 64'(rid_err), 64'(rid != (mem ? 4'h1 : 4'h0)));
            tick();
        end
        {m_rvalid, m_rlast, if_rready, mem_rready} = '0;
        #1;
        chk({tag, "_idle"}, 64'(dut.state), 64'(ARB_IDLE));
        chk({tag, "_no_ar"}, 64'(m_arvalid), 64'd0);
    endtask

    task automatic serve(input bit mem, input bit bad_id);
        int beats;
        logic [3:0] id;
        beats = int'(mem ? mem_arlen : if_arlen) + 1;
        id = mem ? 4'h1 : 4'h0;
        ar_phase(mem, mem ? mem_araddr : if_araddr, mem ? mem_arlen : if_arlen, "rnd");
        r_phase(mem, beats, bad_id ? ~id : id, {$urandom, $urandom}, "rnd");
    endtask

    initial begin
        bit first, rif, rmem;
        reset_dut();
        chk("rst_valids", {58'd0, m_arvalid, if_rvalid, mem_rvalid, m_awvalid, m_wvalid, mem_bvalid}, 64'd0);
        chk("rst_readys", {60'd0, if_arready, mem_arready, m_rready, mem_awready}, 64'd0);
        chk("rst_rid_err", 64'(rid_err), 64'd0);
        chk("rst_state", 64'(dut.state), 64'(ARB_IDLE));
        // if read, single beat
        if_araddr = 64'h8000_0000; if_arlen = 0; if_arsize = 3; if_arburst = 1; if_arvalid = 1;
        #1;
        chk("t1_lat0", 64'(m_arvalid), 64'd0);
        tick();
        chk("t1_lat1", 64'(m_arvalid), 64'd1);
        ar_phase(0, 64'h8000_0000, 0, "t1");
        r_phase(0, 1, 4'h0, 64'hDEAD_BEEF_0000_0001, "t1");
        // simultaneous requests
        reset_dut();
        if_araddr = 64'h1000; if_arlen = 0; if_arvalid = 1;
        mem_araddr = 64'h2000; mem_arlen = 0; mem_arsize = 2; mem_arvalid = 1;
        first = pick_mem(1, 1);
        ar_phase(first, first ? 64'h2000 : 64'h1000, 0, "t2a");
        r_phase(first, 1, first ? 4'h1 : 4'h0, 64'h11, "t2a");
        ar_phase(!first, first ? 64'h1000 : 64'h2000, 0, "t2b");
        r_phase(!first, 1, first ? 4'h0 : 4'h1, 64'h22, "t2b");
        // mem read len 1
        mem_araddr = 64'h3000; mem_arlen = 1; mem_arvalid = 1;
        ar_phase(1, 64'h3000, 1, "t3");
        r_phase(1, 2, 4'h1, 64'h33, "t3");
        // write blocks a later mem read until B; if read still served
        mem_awaddr = 64'h4000; mem_awvalid = 1; m_awready = 1;
        mem_wvalid = 1; mem_wdata = 64'hCAFE_F00D_1234_5678; mem_wstrb = 8'hFF; mem_wlast = 1; m_wready = 1;
        #1;
        chk("t4_awvalid", {62'd0, m_awvalid, mem_awready}, 64'b11);
        chk("t4_awaddr", m_awaddr, 64'h4000);
        chk("t4_awid", 64'(m_awid), 64'h1);
        chk("t4_w", {62'd0, m_wvalid, mem_wready}, 64'b11);
        chk("t4_wdata", m_wdata, 64'hCAFE_F00D_1234_5678);
        tick();
        mem_wvalid = 0; mem_araddr = 64'h5000; mem_arlen = 0; mem_arvalid = 1;
        #1;
        chk("t4_aw_gated", {62'd0, m_awvalid, mem_awready}, 64'd0);
        chk("t4_pend", 64'(dut.wr_pend), 64'd1);
        mem_awvalid = 0; m_awready = 0;
        tick();
        chk("t4_blocked1", 64'(m_arvalid), 64'd0);
        tick();
        chk("t4_blocked2", 64'(m_arvalid), 64'd0);
        if_araddr = 64'h6000; if_arlen = 0; if_arvalid = 1;
        ar_phase(0, 64'h6000, 0, "t4_if");
        r_phase(0, 1, 4'h0, 64'h66, "t4_if");
        tick();
        chk("t4_blocked3", 64'(m_arvalid), 64'd0);
        m_bvalid = 1; m_bresp = 2'd2; mem_bready = 1;
        #1;
        chk("t4_b", {61'd0, mem_bvalid, m_bready, mem_bresp}, {61'd0, 3'b11_0} | 64'b1110);
        chk("t4_blocked4", 64'(m_arvalid), 64'd0);
        tick();
        m_bvalid = 0; mem_bready = 0;
        #1;
        chk("t4_b_clear", 64'(dut.wr_pend), 64'd0);
        chk("t4_arb_lat", 64'(m_arvalid), 64'd0);
        tick();
        chk("t4_mem_gnt", 64'(m_arvalid), 64'd1);
        ar_phase(1, 64'h5000, 0, "t4_mem");
        r_phase(1, 1, 4'h1, 64'h55, "t4_mem");
        // ID mismatch on an if beat
        if_araddr = 64'h7000; if_arlen = 0; if_arvalid = 1;
        ar_phase(0, 64'h7000, 0, "t5");
        r_phase(0, 1, 4'h1, 64'h77, "t5");
        chk("t5_pulse_end", 64'(rid_err), 64'd0);
        // reset in the middle of a mem burst with a write outstanding
        mem_araddr = 64'h9000; mem_arlen = 3; mem_arvalid = 1;
        ar_phase(1, 64'h9000, 3, "t6");
        m_rvalid = 1; m_rdata = 64'h99; m_rid = 4'h1; m_rlast = 0; mem_rready = 1;
        #1;
        chk("t6_beat", 64'(mem_rvalid), 64'd1);
        mem_awvalid = 1; m_awready = 1;
        tick();
        mem_awvalid = 0; m_awready = 0;
        #1;
        chk("t6_pend", 64'(dut.wr_pend), 64'd1);
        rst = 1;
        tick();
        rst = 0; m_rvalid = 0; mem_rready = 0;
        #1;
        chk("t6_state", 64'(dut.state), 64'(ARB_IDLE));
        chk("t6_valids", {60'd0, m_arvalid, if_rvalid, mem_rvalid, m_rready}, 64'd0);
        chk("t6_wr_pend", 64'(dut.wr_pend), 64'd0);
        model_last_mem = 1;
        // randomized request mixes
        for (int it = 0; it < 12; it++) begin
            rif = 1'($urandom); rmem = 1'($urandom);
            if (!rif && !rmem) rif = 1;
            if_araddr = {$urandom, $urandom}; if_arlen = 8'($urandom % 4); if_arsize = 3'($urandom);
            mem_araddr = {$urandom, $urandom}; mem_arlen = 8'($urandom % 4); mem_arsize = 3'($urandom);
            mem_arburst = 2'($urandom);
            if_arvalid = rif; mem_arvalid = rmem;
            first = pick_mem(rif, rmem);
            serve(first, $urandom % 4 == 0);
            if (rif && rmem) serve(!first, $urandom % 4 == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
